sonar_filter: RTL and testbench
===============================

Name: sonar_filter

Overview:
- Downstream consumer of the sonar measurement FSM. Takes its 14-bit distance and Flags[1:0] (bit0 overflow, bit1 interrupt).
- Captures one sample per completed measurement and runs a 3-tap median filter.
- Drives an obstacle flag with hysteresis and a stale/timeout flag for the navigation logic.
- Distances stay in raw sonar counts throughout; no unit conversion.

Parameters:
- NEAR_TH, 14'd1000: obstacle set when filtered distance < NEAR_TH.
- FAR_TH, 14'd1200: obstacle cleared when filtered distance > FAR_TH; NEAR_TH < FAR_TH is checked at elaboration.
- STALE_CYCLES, 24'd5_000_000: cycles without a capture before stale asserts (100 ms at 50 MHz).

Ports:
- clk, in, 1: CLOCK_50, single clock domain.
- reset, in, 1: asynchronous, active-low reset.
- distance_in, in, 14: distance from the sonar FSM.
- flags_in, in, 2: [0] overflow, [1] interrupt, from the sonar FSM.
- clear, in, 1: synchronous flush of the filter.
- dist_filt, out, 14: median-filtered distance.
- dist_valid, out, 1: one-cycle pulse when dist_filt updates.
- obstacle, out, 1: hysteresis obstacle flag; fail-safe high.
- stale, out, 1: no fresh measurement within STALE_CYCLES.

Behaviour:
- Reset values: dist_filt=0, dist_valid=0, obstacle=1, stale=1, window cleared, FSM=FILL0, irq_d=1, stale counter=0.
  - irq_d resets to 1 so an interrupt already high after reset is not a capture.
- Capture event = flags_in[1] & ~irq_d, where irq_d is flags_in[1] registered.
  - One capture per rising edge; interrupt held high for many cycles produces no further captures.
  - Sample is taken the same cycle the edge is seen, while distance_in still holds the final count.
- Sample value: 14'h3FFF (MAX_CODE) if flags_in[0]=1 at capture, else distance_in.
- Window: shift register w2<=w1, w1<=w0, w0<=sample on each capture.
- FSM states and transitions:
  - FILL0 -> FILL1 -> FILL2 -> RUN, advancing on captures 1, 2 and 3.
  - RUN stays in RUN on every capture.
  - clear or stale assertion -> FILL0.
- Output update:
  - On the capture that enters RUN, and every capture in RUN: dist_filt <= median(w0,w1,w2) including the new sample; dist_valid=1 for one cycle.
  - Latency: 1 cycle from capture edge to dist_filt/dist_valid.
  - No dist_valid while filling.
- Obstacle, evaluated on the cycle after dist_valid using the new dist_filt:
  - dist_filt < NEAR_TH -> 1.
  - dist_filt > FAR_TH -> 0.
  - Otherwise hold.
  - Overflow samples therefore count as far.
- Stale:
  - Counter is cleared on capture and increments each cycle, saturating at STALE_CYCLES.
  - stale=1 when counter == STALE_CYCLES; while stale, obstacle is forced to 1 and the window is flushed to FILL0.
  - stale clears on the next capture. obstacle stays 1 until the next RUN evaluation.
- clear: same effect as reset except irq_d is kept. If clear coincides with a capture, clear wins and the sample is discarded.
- Median arithmetic: unsigned 14-bit compares. Ties return the duplicated value.
- An overflow interrupt (FSM in overflow) followed by a normal completion gives two captures only if the interrupt falls in between. The sonar FSM guarantees this via its trigger state.

Decomposition:
- Package sonar_pkg:
  - DIST_W=14, MAX_CODE=14'h3FFF.
  - FLAG_OVF=0, FLAG_IRQ=1.
  - typedef enum fill_state_t {FILL0, FILL1, FILL2, RUN}.
- Sub-module median3: purely combinational, three 14-bit inputs, 14-bit median output. It is shared later for multi-sonar use.

Test Plan:
- Reset release with flags_in=2'b10 held high -> no capture; dist_valid stays 0; obstacle=1, stale=1, dist_filt=0.
- Captures of 500, 1500, 900 (overflow=0) -> no pulse on the first two; after the third, dist_filt=900 with one dist_valid pulse; obstacle=1; stale=0.
- Then captures 1300, then 1400:
  - windows {1500,900,1300} -> 1300, obstacle=0;
  - then {900,1300,1400} -> 1300, obstacle=0.
  - Then 1100: window {1300,1400,1100} -> 1300, obstacle stays 0 (hysteresis band untouched).
- Three overflow captures (flags_in=2'b11 rising, distance_in=42) -> dist_filt=16383, obstacle=0.
- STALE_CYCLES=100 in bench; no capture for 100 cycles after the last -> stale=1 and obstacle=1 exactly 100 cycles later; next three captures of 2000 -> stale=0 after the first, dist_filt=2000 after the third, obstacle=0.
- Two further cases:
  - clear asserted in the same cycle as a capture edge -> sample dropped, FSM=FILL0, no dist_valid.
  - reset asserted asynchronously mid-FILL2 -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar measurement post-processing blocks.
package sonar_pkg;

  localparam int unsigned DIST_W   = 14;
  localparam int unsigned CNT_W    = 24;
  localparam logic [DIST_W-1:0] MAX_CODE = 14'h3FFF;

  localparam int unsigned FLAG_OVF = 0;
  localparam int unsigned FLAG_IRQ = 1;

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    FILL2,
    RUN
  } fill_state_t;

endpackage

// File: rtl/median3.sv
// Combinational median of three unsigned distances; ties return the duplicated value.
module median3
  import sonar_pkg::*;
(
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  output logic [DIST_W-1:0] med_c
);

  logic [DIST_W-1:0] lo_ab;
  logic [DIST_W-1:0] hi_ab;
  logic [DIST_W-1:0] hi_min_c;

  // median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab    = (a < b) ? a : b;
    hi_ab    = (a < b) ? b : a;
    hi_min_c = (hi_ab < c) ? hi_ab : c;
    med_c    = (lo_ab > hi_min_c) ? lo_ab : hi_min_c;
  end

endmodule

// File: rtl/sonar_filter.sv
// Median-filters sonar distances per completed measurement and drives
// hysteresis obstacle and stale flags for navigation.
module sonar_filter
  import sonar_pkg::*;
#(
  parameter logic [DIST_W-1:0] NEAR_TH      = 14'd1000,
  parameter logic [DIST_W-1:0] FAR_TH       = 14'd1200,
  parameter logic [CNT_W-1:0]  STALE_CYCLES = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIST_W-1:0] distance_in,
  input  logic [1:0]        flags_in,
  input  logic              clear,
  output logic [DIST_W-1:0] dist_filt,
  output logic              dist_valid,
  output logic              obstacle,
  output logic              stale
);

  generate
    if (NEAR_TH >= FAR_TH) begin : g_th_check
      $error("sonar_filter: NEAR_TH must be below FAR_TH");
    end
  endgenerate

  fill_state_t       state_q;
  fill_state_t       state_d;
  logic              irq_d;
  logic [DIST_W-1:0] w0;
  logic [DIST_W-1:0] w1;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              capture_c;
  logic              stale_d_c;
  logic              flush_c;
  logic              upd_c;
  logic [DIST_W-1:0] sample_c;
  logic [DIST_W-1:0] med_c;

  // Capture on the interrupt rising edge; overflow reads as the farthest code.
  always_comb begin
    capture_c = flags_in[FLAG_IRQ] & ~irq_d;
    sample_c  = flags_in[FLAG_OVF] ? MAX_CODE : distance_in;
  end

  // Stale counter and sticky stale flag; only a capture clears stale.
  always_comb begin
    cnt_d = cnt_q;
    if (capture_c) begin
      cnt_d = '0;
    end else if (cnt_q != STALE_CYCLES) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    stale_d_c = ~capture_c & (stale | (cnt_d == STALE_CYCLES));
    flush_c   = clear | stale_d_c;
  end

  // The oldest tap of the new window is the w1 being shifted out, so it is never stored.
  median3 u_median3 (
    .a     (sample_c),
    .b     (w0),
    .c     (w1),
    .med_c (med_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    upd_c   = 1'b0;
    if (flush_c) begin
      state_d = FILL0;
    end else if (capture_c) begin
      unique case (state_q)
        FILL0: state_d = FILL1;
        FILL1: state_d = FILL2;
        FILL2: begin
          state_d = RUN;
          upd_c   = 1'b1;
        end
        RUN: begin
          state_d = RUN;
          upd_c   = 1'b1;
        end
        default: state_d = FILL0;
      endcase
    end
  end

  // Interrupt edge history survives clear so a held interrupt is not re-captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d <= 1'b1;
    end else begin
      irq_d <= flags_in[FLAG_IRQ];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0         <= '0;
      w1         <= '0;
      cnt_q      <= '0;
      stale      <= 1'b1;
      dist_filt  <= '0;
      dist_valid <= 1'b0;
      obstacle   <= 1'b1;
    end else begin
      dist_valid <= upd_c;
      if (clear) begin
        w0        <= '0;
        w1        <= '0;
        cnt_q     <= '0;
        stale     <= 1'b1;
        dist_filt <= '0;
        obstacle  <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        stale <= stale_d_c;
        if (stale_d_c) begin
          w0 <= '0;
          w1 <= '0;
        end else if (capture_c) begin
          w1 <= w0;
          w0 <= sample_c;
        end
        if (upd_c) begin
          dist_filt <= med_c;
        end
        // Hysteresis evaluated one cycle after the filtered value lands.
        if (stale_d_c) begin
          obstacle <= 1'b1;
        end else if (dist_valid) begin
          if (dist_filt < NEAR_TH) begin
            obstacle <= 1'b1;
          end else if (dist_filt > FAR_TH) begin
            obstacle <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_filter.sv
// Scoreboard bench for sonar_filter: directed captures push expected medians,
// a negedge monitor pops and compares on every dist_valid pulse.
module tb_sonar_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] distance_in;
  logic [1:0]  flags_in;
  logic        clear;
  logic [13:0] dist_filt;
  logic        dist_valid;
  logic        obstacle;
  logic        stale;

  int          checks = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  sonar_filter #(
    .NEAR_TH      (14'd1000),
    .FAR_TH       (14'd1200),
    .STALE_CYCLES (24'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .distance_in (distance_in),
    .flags_in    (flags_in),
    .clear       (clear),
    .dist_filt   (dist_filt),
    .dist_valid  (dist_valid),
    .obstacle    (obstacle),
    .stale       (stale)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One interrupt rising edge; returns on the negedge right after the capture edge.
  task automatic cap(input logic [13:0] d, input logic ovf, input logic push, input logic [13:0] e);
    @(negedge clk);
    distance_in = d;
    flags_in    = {1'b1, ovf};
    if (push) exp_q.push_back(e);
    @(negedge clk);
    flags_in = 2'b00;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest expected median.
  always @(negedge clk) begin
    if (reset && dist_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got dist_valid=1 dist_filt=%0d expected no pulse", dist_filt);
      end else begin
        check("dist_filt_pulse", 32'(dist_filt), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    flags_in    = 2'b10;
    distance_in = '0;
    clear       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dist_filt", 32'(dist_filt), 0);
    check("rst_dist_valid", 32'(dist_valid), 0);
    check("rst_obstacle", 32'(obstacle), 1);
    check("rst_stale", 32'(stale), 1);
    flags_in = 2'b00;
    @(negedge clk);

    // Fill then first median.
    cap(14'd500, 1'b0, 1'b0, 14'd0);
    cap(14'd1500, 1'b0, 1'b0, 14'd0);
    cap(14'd900, 1'b0, 1'b1, 14'd900);
    settle();
    check("fill_obstacle", 32'(obstacle), 1);
    check("fill_stale", 32'(stale), 0);

    cap(14'd1300, 1'b0, 1'b1, 14'd1300);
    settle();
    check("run1300_obstacle", 32'(obstacle), 0);
    cap(14'd1400, 1'b0, 1'b1, 14'd1300);
    settle();
    check("run1400_obstacle", 32'(obstacle), 0);
    cap(14'd1100, 1'b0, 1'b1, 14'd1300);
    settle();
    check("hyst_obstacle", 32'(obstacle), 0);

    // Overflow samples read as MAX_CODE.
    cap(14'd42, 1'b1, 1'b1, 14'd1400);
    cap(14'd42, 1'b1, 1'b1, 14'd16383);
    cap(14'd42, 1'b1, 1'b1, 14'd16383);
    check("ovf_dist_filt", 32'(dist_filt), 16383);
    repeat (99) @(negedge clk);
    check("pre_stale", 32'(stale), 0);
    check("pre_stale_obstacle", 32'(obstacle), 0);
    @(negedge clk);
    check("stale_set", 32'(stale), 1);
    check("stale_obstacle", 32'(obstacle), 1);

    cap(14'd2000, 1'b0, 1'b0, 14'd0);
    check("stale_clear", 32'(stale), 0);
    cap(14'd2000, 1'b0, 1'b0, 14'd0);
    cap(14'd2000, 1'b0, 1'b1, 14'd2000);
    settle();
    check("refill_dist_filt", 32'(dist_filt), 2000);
    check("refill_obstacle", 32'(obstacle), 0);

    // clear coinciding with a capture edge drops the sample.
    @(negedge clk);
    distance_in = 14'd3000;
    flags_in    = 2'b10;
    clear       = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    flags_in = 2'b00;
    check("clr_dist_valid", 32'(dist_valid), 0);
    check("clr_dist_filt", 32'(dist_filt), 0);
    check("clr_obstacle", 32'(obstacle), 1);
    check("clr_stale", 32'(stale), 1);
    cap(14'd700, 1'b0, 1'b0, 14'd0);
    cap(14'd800, 1'b0, 1'b0, 14'd0);
    cap(14'd600, 1'b0, 1'b1, 14'd700);
    settle();
    check("post_clr_dist_filt", 32'(dist_filt), 700);
    check("post_clr_obstacle", 32'(obstacle), 1);

    // Go stale (dist_filt held), refill to FILL2, then async reset.
    repeat (101) @(negedge clk);
    check("stale2_set", 32'(stale), 1);
    check("stale2_dist_hold", 32'(dist_filt), 700);
    cap(14'd100, 1'b0, 1'b0, 14'd0);
    cap(14'd200, 1'b0, 1'b0, 14'd0);
    check("fill2_stale", 32'(stale), 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_dist_filt", 32'(dist_filt), 0);
    check("async_stale", 32'(stale), 1);
    check("async_obstacle", 32'(obstacle), 1);
    check("async_dist_valid", 32'(dist_valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    cap(14'd300, 1'b0, 1'b0, 14'd0);
    cap(14'd300, 1'b0, 1'b0, 14'd0);
    cap(14'd5000, 1'b0, 1'b1, 14'd300);
    settle();
    check("post_rst_dist_filt", 32'(dist_filt), 300);
    check("post_rst_obstacle", 32'(obstacle), 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
